// File: rtl/my_riscv_defines.sv
// Shared core definitions: interrupt controller state encoding and sizing constants.
package my_riscv_defines;

  typedef enum logic [1:0] {
    IRQ_IDLE = 2'd0,
    IRQ_REQ  = 2'd1,
    IRQ_ISR  = 2'd2
  } irq_state_t;

  localparam int IRQ_ID_BASE     = 16;
  localparam int IRQ_NUM_SRC_MAX = 16;
  localparam int IRQ_IDX_W       = 4;

endpackage

// File: rtl/my_irq_sync.sv
// Two-flop synchronizer per line plus a delay flop giving a one-cycle rising-edge pulse.
module my_irq_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_level,
  output logic [WIDTH-1:0] o_rise
);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_dly;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1  <= '0;
      r_s2  <= '0;
      r_dly <= '0;
    end else begin
      r_s1  <= i_async;
      r_s2  <= r_s1;
      r_dly <= r_s2;
    end
  end

  assign o_level = r_s2;
  assign o_rise  = r_s2 & ~r_dly;

endmodule

// File: rtl/my_irq_ctrl.sv
// Interrupt controller: latches, masks and priority-selects external sources and
// tracks the single in-service interrupt until MRET.
//   state    | meaning
//   IRQ_IDLE | no request outstanding, waiting for an enabled pending source
//   IRQ_REQ  | request presented to core, id frozen until take or withdraw
//   IRQ_ISR  | core in handler, waiting for MRET (irq_done_i)
module my_irq_ctrl
  import my_riscv_defines::*;
#(
  parameter int                 NUM_SRC  = IRQ_NUM_SRC_MAX,
  parameter logic [NUM_SRC-1:0] SRC_EDGE = {NUM_SRC{1'b1}},
  parameter int                 ID_BASE  = IRQ_ID_BASE
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               fetch_ready_i,
  input  logic [NUM_SRC-1:0] irq_src_i,
  input  logic               mstatus_mie_i,
  input  logic               en_we_i,
  input  logic [NUM_SRC-1:0] en_wdata_i,
  output logic [NUM_SRC-1:0] en_o,
  output logic [NUM_SRC-1:0] pending_o,
  output logic               irq_req_o,
  output logic               irq_o,
  output logic [4:0]         irq_id_o,
  input  logic               irq_taken_i,
  input  logic               irq_done_i
);

  localparam logic [4:0] ID_BASE_L = 5'(ID_BASE);

  logic [NUM_SRC-1:0]   w_level;
  logic [NUM_SRC-1:0]   w_rise;
  logic [NUM_SRC-1:0]   w_active;
  logic [NUM_SRC-1:0]   w_sel_oh;
  logic [NUM_SRC-1:0]   w_clr;
  logic [NUM_SRC-1:0]   w_pend_nxt;
  logic                 w_found;
  logic [IRQ_IDX_W-1:0] w_idx;
  logic                 w_sel_active;
  logic                 w_take;

  logic [NUM_SRC-1:0]   r_en;
  logic [NUM_SRC-1:0]   r_pend;
  irq_state_t           r_state;
  logic                 r_req;
  logic [IRQ_IDX_W-1:0] r_sel;
  logic [4:0]           r_id;

  my_irq_sync #(
    .WIDTH (NUM_SRC)
  ) u_sync (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_async (irq_src_i),
    .o_level (w_level),
    .o_rise  (w_rise)
  );

  assign w_active = r_pend & r_en;

  // Scan high to low so the lowest active index is the last one written.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_active[i]) begin
        w_found = 1'b1;
        w_idx   = IRQ_IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_sel_oh = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_sel_oh[i] = (r_sel == IRQ_IDX_W'(i));
    end
  end

  assign w_sel_active = |(w_active & w_sel_oh);
  assign w_take       = (r_state == IRQ_REQ) && fetch_ready_i && irq_taken_i;
  assign w_clr        = w_take ? (w_sel_oh & SRC_EDGE) : '0;

  // A fresh edge beats a same-cycle take so it is never lost.
  assign w_pend_nxt = (SRC_EDGE & (w_rise | (r_pend & ~w_clr))) | (~SRC_EDGE & w_level);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pend <= '0;
      r_en   <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      if (en_we_i && fetch_ready_i) begin
        r_en <= en_wdata_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IRQ_IDLE;
      r_req   <= 1'b0;
      r_sel   <= '0;
      r_id    <= '0;
    end else if (fetch_ready_i) begin
      case (r_state)
        IRQ_IDLE: begin
          if (mstatus_mie_i && w_found) begin
            r_state <= IRQ_REQ;
            r_req   <= 1'b1;
            r_sel   <= w_idx;
            r_id    <= ID_BASE_L + {1'b0, w_idx};
          end
        end
        IRQ_REQ: begin
          if (irq_taken_i) begin
            r_state <= IRQ_ISR;
            r_req   <= 1'b0;
          end else if (!mstatus_mie_i || !w_sel_active) begin
            r_state <= IRQ_IDLE;
            r_req   <= 1'b0;
          end
        end
        IRQ_ISR: begin
          if (irq_done_i) begin
            r_state <= IRQ_IDLE;
          end
        end
        default: begin
          r_state <= IRQ_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign en_o      = r_en;
  assign pending_o = r_pend;
  assign irq_req_o = r_req;
  assign irq_o     = r_req;
  assign irq_id_o  = r_id;

endmodule

// File: tb/tb_my_irq_ctrl.sv
// Self-checking bench for my_irq_ctrl: directed scenarios plus random traffic against a cycle model.
module tb_my_irq_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        fetch_ready_i = 1'b1;
  logic [15:0] irq_src_i = '0;
  logic        mstatus_mie_i = 1'b1;
  logic        en_we_i = 1'b0;
  logic [15:0] en_wdata_i = '0;
  logic [15:0] en_o;
  logic [15:0] pending_o;
  logic        irq_req_o;
  logic        irq_o;
  logic [4:0]  irq_id_o;
  logic        irq_taken_i = 1'b0;
  logic        irq_done_i = 1'b0;

  my_irq_ctrl #(
    .NUM_SRC  (16),
    .SRC_EDGE (16'hFFF7),
    .ID_BASE  (16)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .fetch_ready_i (fetch_ready_i),
    .irq_src_i     (irq_src_i),
    .mstatus_mie_i (mstatus_mie_i),
    .en_we_i       (en_we_i),
    .en_wdata_i    (en_wdata_i),
    .en_o          (en_o),
    .pending_o     (pending_o),
    .irq_req_o     (irq_req_o),
    .irq_o         (irq_o),
    .irq_id_o      (irq_id_o),
    .irq_taken_i   (irq_taken_i),
    .irq_done_i    (irq_done_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: mode 0 = idle, 1 = requesting, 2 = in service.
  logic [15:0] edge_mask = 16'hFFF7;
  logic [15:0] h1, h2, h3;
  logic [15:0] m_en, m_pend;
  int          m_mode, m_sel;
  logic [4:0]  m_id;
  logic [15:0] g_src = '0;
  logic        g_mie = 1'b1;

  function automatic int lowest(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    h1 = '0; h2 = '0; h3 = '0;
    m_en = '0; m_pend = '0;
    m_mode = 0; m_sel = 0; m_id = '0;
  endtask

  task automatic model_next(input logic [15:0] src, input logic mie, fr, we,
                            input logic [15:0] wd, input logic tk, dn);
    logic [15:0] act, clr, rise, np;
    act  = m_pend & m_en;
    clr  = '0;
    rise = h2 & ~h3;
    if (fr) begin
      if (m_mode == 0) begin
        if (mie && act != 0) begin
          m_mode = 1;
          m_sel  = lowest(act);
          m_id   = 5'(16 + m_sel);
        end
      end else if (m_mode == 1) begin
        if (tk) begin
          m_mode = 2;
          if (edge_mask[m_sel]) clr[m_sel] = 1'b1;
        end else if (!mie || !act[m_sel]) begin
          m_mode = 0;
        end
      end else if (dn) begin
        m_mode = 0;
      end
      if (we) m_en = wd;
    end
    for (int i = 0; i < 16; i++)
      np[i] = edge_mask[i] ? (rise[i] | (m_pend[i] & ~clr[i])) : h2[i];
    m_pend = np;
    h3 = h2; h2 = h1; h1 = src;
  endtask

  task automatic step(input logic [15:0] src, input logic mie, fr, we,
                      input logic [15:0] wd, input logic tk, dn);
    chk("en_o", en_o, m_en);
    chk("pending_o", pending_o, m_pend);
    chk("irq_req_o", irq_req_o, m_mode == 1);
    chk("irq_o", irq_o, m_mode == 1);
    chk("irq_id_o", irq_id_o, m_id);
    irq_src_i = src; mstatus_mie_i = mie; fetch_ready_i = fr;
    en_we_i = we; en_wdata_i = wd; irq_taken_i = tk; irq_done_i = dn;
    model_next(src, mie, fr, we, wd, tk, dn);
    @(negedge clk_i);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) step(g_src, g_mie, 1'b1, 1'b0, '0, 1'b0, 1'b0);
  endtask
  task automatic pulse(input logic [15:0] m);
    step(g_src | m, g_mie, 1'b1, 1'b0, '0, 1'b0, 1'b0);
  endtask
  task automatic take();
    step(g_src, g_mie, 1'b1, 1'b0, '0, 1'b1, 1'b0);
  endtask
  task automatic done();
    step(g_src, g_mie, 1'b1, 1'b0, '0, 1'b0, 1'b1);
  endtask
  task automatic wr_en(input logic [15:0] v);
    step(g_src, g_mie, 1'b1, 1'b1, v, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk_i);
    chk("rst_req", irq_req_o, 0);
    chk("rst_id", irq_id_o, 0);
    chk("rst_en", en_o, 0);
    chk("rst_pend", pending_o, 0);
    rst_ni = 1'b1;

    // single edge source, full latency
    wr_en(16'h0004);
    pulse(16'h0004);
    tick(2);
    chk("lat_pend3", pending_o[2], 1);
    chk("lat_req3", irq_req_o, 0);
    tick(1);
    chk("lat_req4", irq_req_o, 1);
    chk("lat_id", irq_id_o, 18);
    take();
    chk("take_clr", pending_o[2], 0);
    chk("take_req", irq_req_o, 0);
    done();
    tick(2);
    chk("done_idle", irq_req_o, 0);

    // priority: 1 beats 5
    wr_en(16'hFFFF);
    pulse(16'h0022);
    tick(3);
    chk("prio_id17", irq_id_o, 17);
    take();
    done();
    tick(1);
    chk("prio_req21", irq_req_o, 1);
    chk("prio_id21", irq_id_o, 21);
    take();
    done();
    tick(2);

    // withdraw on MIE drop, re-request on restore
    pulse(16'h0002);
    tick(3);
    step(g_src, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    chk("wd_req", irq_req_o, 0);
    chk("wd_pend", pending_o[1], 1);
    tick(1);
    chk("wd_rereq", irq_req_o, 1);
    chk("wd_id", irq_id_o, 17);
    take();
    done();
    tick(2);

    // level source 3
    g_src = 16'h0008;
    tick(4);
    chk("lvl_id", irq_id_o, 19);
    take();
    chk("lvl_pend", pending_o[3], 1);
    done();
    tick(1);
    chk("lvl_rereq", irq_req_o, 1);
    take();
    g_src = '0;
    tick(3);
    done();
    tick(2);
    chk("lvl_norereq", irq_req_o, 0);

    // edges on source 0 while in service and coincident with take
    pulse(16'h0001);
    tick(3);
    take();
    pulse(16'h0001);
    tick(3);
    chk("isr_pend0", pending_o[0], 1);
    done();
    tick(1);
    chk("isr_rereq", irq_req_o, 1);
    chk("isr_id", irq_id_o, 16);
    pulse(16'h0001);
    tick(1);
    take();
    chk("coinc_pend0", pending_o[0], 1);
    done();
    tick(1);
    chk("coinc_rereq", irq_req_o, 1);
    take();
    done();
    tick(2);

    // frozen pipeline, then reset mid-ISR
    pulse(16'h0001);
    tick(3);
    for (int i = 0; i < 5; i++) step(g_src, g_mie, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    chk("frz_req", irq_req_o, 1);
    chk("frz_en", en_o, 16'hFFFF);
    take();
    chk("frz_isr", irq_req_o, 0);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_req", irq_req_o, 0);
    chk("arst_irq", irq_o, 0);
    chk("arst_id", irq_id_o, 0);
    chk("arst_en", en_o, 0);
    chk("arst_pend", pending_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    model_reset();

    // random traffic
    g_src = '0;
    for (int c = 0; c < 3000; c++) begin
      logic fr, we, tk, dn;
      logic [15:0] wd;
      if ($urandom_range(0, 7) == 0) g_src = g_src ^ (16'(1) << $urandom_range(0, 15));
      g_mie = ($urandom_range(0, 9) != 0);
      fr    = ($urandom_range(0, 4) != 0);
      we    = ($urandom_range(0, 19) == 0);
      wd    = 16'($urandom);
      tk    = (m_mode == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      dn    = (m_mode == 2) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 9) == 0);
      step(g_src, g_mie, fr, we, wd, tk, dn);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
